// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH
// Optional MULT_SIGN_SEL_EN adds is_signed to select signed/unsigned operand extension.
module seq_booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGN_SEL_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N-1:0]       acc_q;
    logic [N-1:0]       mq_q;
    logic [N-1:0]       mcand_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] out_q;

    logic               sext;
    logic [N-1:0]       acc_d;

`ifdef MULT_SIGN_SEL_EN
    assign sext = is_signed;
`else
    assign sext = 1'b1;
`endif

    // The add/subtract is done in N bits; any carry out is meaningless for Booth and dropped.
    always_comb begin
        acc_d = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   acc_d = acc_q + mcand_q;
            2'b10:   acc_d = acc_q - mcand_q;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= start;
                    if (start) begin
                        acc_q   <= '0;
                        mq_q    <= {sext & b[WIDTH-1], b};
                        mcand_q <= {sext & a[WIDTH-1], a};
                        qm1_q   <= 1'b0;
                        cnt_q   <= CW'(N);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= {acc_d[N-1], acc_d[N-1:1]};
                    mq_q  <= {acc_d[0], mq_q[N-1:1]};
                    qm1_q <= mq_q[0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // {A,Q} is 2*WIDTH+2 bits wide; the product lives in its low 2*WIDTH bits.
                    out_q   <= {acc_q[N-3:0], mq_q};
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - directed self-checking bench for seq_booth_multiplier
// Exercises the MULT_SIGN_SEL_EN vectors only when that macro is defined.
module tb_seq_booth_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        sgn;

    logic        start5;
    logic [4:0]  a5;
    logic [4:0]  b5;
    logic        busy5;
    logic        done5;
    logic [9:0]  out5;

    int cmp_cnt;
    int err_cnt;
    int cyc;

    seq_booth_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef MULT_SIGN_SEL_EN
        .is_signed (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .out       (out)
    );

    seq_booth_multiplier #(.WIDTH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start5),
        .a         (a5),
        .b         (b5),
`ifdef MULT_SIGN_SEL_EN
        .is_signed (sgn),
`endif
        .busy      (busy5),
        .done      (done5),
        .out       (out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic run8(input logic [7:0] aa, input logic [7:0] bb, output int lat);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 40 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b done=%b out=%h, want 0 0 0000", busy, done, out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic [15:0] vp [5];
        int lat;
        va = '{8'hE5, 8'hFB, 8'h80, 8'h7F, 8'h00};
        vb = '{8'h95, 8'h04, 8'h80, 8'h80, 8'hFF};
        vp = '{16'h0B49, 16'hFFEC, 16'h4000, 16'hC080, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            run8(va[i], vb[i], lat);
            cmp_cnt++;
            if (lat !== 10) begin
                err_cnt++;
                $display("FAIL latency_%0d: edges=%0d, want 10", i, lat);
            end
            cmp_cnt++;
            if (out !== vp[i]) begin
                err_cnt++;
                $display("FAIL product_%0d: %h*%h out=%h, want %h", i, va[i], vb[i], out, vp[i]);
            end
            @(posedge clk);
            #1;
            cmp_cnt++;
            if (done !== 1'b0 || busy !== 1'b0 || out !== vp[i]) begin
                err_cnt++;
                $display("FAIL after_done_%0d: done=%b busy=%b out=%h, want 0 0 %h", i, done, busy, out, vp[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int pulses;
        logic [15:0] seen;
        @(negedge clk);
        a = 8'hE5;
        b = 8'h95;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 8'h11;
        b = 8'h22;
        pulses = 0;
        seen = 16'hxxxx;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'h02;
        b = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                seen = out;
            end
        end
        cmp_cnt++;
        if (pulses !== 1) begin
            err_cnt++;
            $display("FAIL ignore_pulses: done pulses=%0d, want 1", pulses);
        end
        cmp_cnt++;
        if (seen !== 16'h0B49 || out !== 16'h0B49 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ignore_product: seen=%h out=%h busy=%b, want 0B49 0B49 0", seen, out, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dn;
        @(negedge clk);
        a = 8'h7F;
        b = 8'h7F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_mid: busy=%b done=%b out=%h, want 0 0 0000", busy, done, out);
        end
        dn = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) dn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) dn++;
        end
        cmp_cnt++;
        if (dn !== 0) begin
            err_cnt++;
            $display("FAIL reset_no_done: stray done cycles=%0d, want 0", dn);
        end
        run8(8'h03, 8'hFD, lat);
        cmp_cnt++;
        if (lat !== 10 || out !== 16'hFFF7) begin
            err_cnt++;
            $display("FAIL reset_recover: edges=%0d out=%h, want 10 FFF7", lat, out);
        end
    endtask

    task automatic test_sign_sel;
`ifdef MULT_SIGN_SEL_EN
        int lat;
        sgn = 1'b0;
        run8(8'hFF, 8'hFF, lat);
        cmp_cnt++;
        if (lat !== 10 || out !== 16'hFE01) begin
            err_cnt++;
            $display("FAIL unsigned_ff: edges=%0d out=%h, want 10 FE01", lat, out);
        end
        sgn = 1'b1;
        run8(8'hFF, 8'hFF, lat);
        cmp_cnt++;
        if (lat !== 10 || out !== 16'h0001) begin
            err_cnt++;
            $display("FAIL signed_ff: edges=%0d out=%h, want 10 0001", lat, out);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [6];
        logic [7:0] ob [6];
        logic signed [15:0] exp;
        int t_prev;
        int n;
        for (int i = 0; i < 6; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
        end
        @(negedge clk);
        a = oa[0];
        b = ob[0];
        start = 1'b1;
        t_prev = -1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (done !== 1'b1 && n < 40);
            exp = $signed(oa[i]) * $signed(ob[i]);
            cmp_cnt++;
            if (out !== exp || n >= 40) begin
                err_cnt++;
                $display("FAIL b2b_product_%0d: %h*%h out=%h, want %h", i, oa[i], ob[i], out, exp);
            end
            if (t_prev >= 0) begin
                cmp_cnt++;
                if (cyc - t_prev !== 11) begin
                    err_cnt++;
                    $display("FAIL b2b_period_%0d: %0d cycles, want 11", i, cyc - t_prev);
                end
            end
            t_prev = cyc;
            if (i < 5) begin
                a = oa[i+1];
                b = ob[i+1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_width5;
        logic [4:0] xa;
        logic [4:0] xb;
        logic signed [9:0] exp;
        int lat;
        for (int i = 0; i < 10; i++) begin
            xa = (i == 0) ? 5'h10 : 5'($urandom);
            xb = (i == 0) ? 5'h10 : 5'($urandom);
            @(negedge clk);
            a5 = xa;
            b5 = xb;
            start5 = 1'b1;
            @(posedge clk);
            #1 start5 = 1'b0;
            lat = 0;
            while (lat < 40 && done5 !== 1'b1) begin
                @(posedge clk);
                #1;
                lat++;
            end
            exp = $signed(xa) * $signed(xb);
            cmp_cnt++;
            if (lat !== 7 || out5 !== exp) begin
                err_cnt++;
                $display("FAIL w5_%0d: %h*%h edges=%0d out=%h, want 7 %h", i, xa, xb, lat, out5, exp);
            end
        end
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        cyc = 0;
        start = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b1;
        start5 = 1'b0;
        a5 = '0;
        b5 = '0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_sign_sel();
        test_back_to_back();
        test_width5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
